// File: rtl/rmt_pkg.sv
// Shared constants, types and helpers for the ingress header parser.
// PHV layout, parse-action encoding and the parser state enum live here.
package rmt_pkg;

    localparam int unsigned AXIS_DATA_W = 256;
    localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;
    localparam int unsigned AXIS_USER_W = 128;
    localparam int unsigned PKT_VEC_W   = 1124;
    localparam int unsigned NUM_ACTIONS = 10;
    localparam int unsigned ACT_W       = 16;
    localparam int unsigned ACT_RAM_W   = 260;
    localparam int unsigned ACT_ADDR_W  = 4;
    localparam int unsigned ACT_BASE0   = 244;
    localparam int unsigned ACT_STRIDE  = 16;
    localparam int unsigned ACT_LOW_POS = ACT_BASE0 - ACT_STRIDE * (NUM_ACTIONS - 1);

    localparam int unsigned HDR_BEATS   = 4;
    localparam int unsigned BEAT_CNT_W  = 2;
    localparam int unsigned HDR_BYTES   = 128;
    localparam int unsigned HDR_W       = HDR_BYTES * 8;
    localparam int unsigned FIELD_BYTES = 6;
    localparam int unsigned FIELD_W     = FIELD_BYTES * 8;

    // VLAN id = {low nibble of byte 14, byte 15}
    localparam int unsigned VLAN_W      = 12;
    localparam int unsigned VLAN_HI_POS = 112;
    localparam int unsigned VLAN_LO_POS = 120;

    localparam int unsigned PHV_META_POS     = 0;
    localparam int unsigned PHV_VLAN_POS     = 129;
    localparam int unsigned PHV_2B_START_POS = 356;
    localparam int unsigned PHV_4B_START_POS = 484;
    localparam int unsigned PHV_6B_START_POS = 740;
    localparam int unsigned PHV_IDX_W        = 11;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_2B   = 2'b01;
    localparam logic [1:0] TYPE_4B   = 2'b10;
    localparam logic [1:0] TYPE_6B   = 2'b11;

    typedef struct packed {
        logic [2:0] pad;
        logic [6:0] offset;
        logic [1:0] kind;
        logic [2:0] idx;
        logic       valid;
    } action_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOOKUP,
        EXTRACT,
        EMIT,
        BODY
    } state_t;

    function automatic int act_base(input int i);
        return int'(ACT_BASE0) - int'(ACT_STRIDE) * i;
    endfunction

    // Bit position of container idx of the given size class inside the PHV
    function automatic logic [PHV_IDX_W-1:0] container_base(input logic [1:0] kind,
                                                            input logic [2:0] idx);
        case (kind)
            TYPE_4B: return PHV_IDX_W'(PHV_4B_START_POS) + PHV_IDX_W'({idx, 5'd0});
            TYPE_6B: return PHV_IDX_W'(PHV_6B_START_POS) + PHV_IDX_W'(idx) * PHV_IDX_W'(48);
            default: return PHV_IDX_W'(PHV_2B_START_POS) + PHV_IDX_W'({idx, 4'd0});
        endcase
    endfunction

endpackage

// File: rtl/header_parser_field_extract.sv
// Decodes one parse action and pulls up to 6 header bytes starting at its offset.
// Bytes past the 128 B header window read as zero.
module field_extract
    import rmt_pkg::*;
(
    input  logic [HDR_W-1:0]   hdr,
    input  logic [ACT_W-1:0]   action,
    output logic [FIELD_W-1:0] value,
    output logic [1:0]         kind,
    output logic [2:0]         idx,
    output logic               valid
);

    action_t    act;
    logic [7:0] pos;
    logic       unused_pad;

    assign act        = action_t'(action);
    assign kind       = act.kind;
    assign idx        = act.idx;
    assign valid      = act.valid && (act.kind != TYPE_NONE);
    assign unused_pad = ^act.pad;

    always_comb begin
        value = '0;
        pos   = '0;
        for (int j = 0; j < int'(FIELD_BYTES); j++) begin
            pos = 8'(act.offset) + 8'(j);
            if (pos < 8'(HDR_BYTES)) begin
                value[8*j +: 8] = hdr[{pos[6:0], 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/header_parser.sv
// Ingress header parser: captures up to 4 header beats, applies the per-VLAN
// parse actions to build a PHV, and forwards the packet unchanged in order.
module header_parser
    import rmt_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic [AXIS_USER_W-1:0] s_axis_tuser,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [AXIS_DATA_W-1:0] m_pkt_tdata,
    output logic [AXIS_KEEP_W-1:0] m_pkt_tkeep,
    output logic [AXIS_USER_W-1:0] m_pkt_tuser,
    output logic                   m_pkt_tlast,
    output logic                   m_pkt_tvalid,
    input  logic                   m_pkt_tready,
    output logic [PKT_VEC_W-1:0]   phv_out,
    output logic                   phv_valid,
    input  logic                   phv_ready,
    output logic [ACT_ADDR_W-1:0]  act_ram_addr,
    input  logic [ACT_RAM_W-1:0]   act_ram_dout
);

    state_t state, state_next;

    logic                                  pass;
    logic                                  beat;
    logic [HDR_BEATS-1:0][AXIS_DATA_W-1:0] hdr_buf;
    logic [HDR_W-1:0]                      hdr_flat;
    logic [BEAT_CNT_W-1:0]                 count;
    logic                                  hdr_last;
    logic [AXIS_USER_W-1:0]                meta;
    logic [VLAN_W-1:0]                     vlan_id;
    logic [VLAN_W-1:0]                     vlan_in;
    logic [PKT_VEC_W-1:0]                  phv_next;
    logic [PHV_IDX_W-1:0]                  base;
    logic                                  unused_ram;

    logic [FIELD_W-1:0]     fx_value [NUM_ACTIONS];
    logic [1:0]             fx_kind  [NUM_ACTIONS];
    logic [2:0]             fx_idx   [NUM_ACTIONS];
    logic [NUM_ACTIONS-1:0] fx_valid;

    // Stream passes straight through only while capturing or forwarding body
    assign pass          = (state == IDLE) || (state == HDR) || (state == BODY);
    assign s_axis_tready = pass && m_pkt_tready && !rst;
    assign m_pkt_tvalid  = pass && s_axis_tvalid && !rst;
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign m_pkt_tdata   = s_axis_tdata;
    assign m_pkt_tkeep   = s_axis_tkeep;
    assign m_pkt_tuser   = s_axis_tuser;
    assign m_pkt_tlast   = s_axis_tlast;

    assign vlan_in    = {s_axis_tdata[VLAN_HI_POS +: 4], s_axis_tdata[VLAN_LO_POS +: 8]};
    assign hdr_flat   = hdr_buf;
    assign unused_ram = ^act_ram_dout[ACT_LOW_POS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (beat) begin
                    state_next = s_axis_tlast ? LOOKUP : HDR;
                end
            end
            HDR: begin
                if (beat && (s_axis_tlast || (count == BEAT_CNT_W'(HDR_BEATS - 1)))) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP:  state_next = EXTRACT;
            EXTRACT: state_next = EMIT;
            EMIT: begin
                if (phv_valid && phv_ready) begin
                    state_next = hdr_last ? IDLE : BODY;
                end
            end
            BODY: begin
                if (beat && s_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Header capture, lookup address, PHV register
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_buf      <= '0;
            count        <= '0;
            hdr_last     <= 1'b0;
            meta         <= '0;
            vlan_id      <= '0;
            act_ram_addr <= '0;
            phv_out      <= '0;
            phv_valid    <= 1'b0;
        end else begin
            phv_valid <= (state_next == EMIT);
            if ((state != IDLE) && (state_next == IDLE)) begin
                hdr_buf <= '0;
                count   <= '0;
            end
            case (state)
                IDLE: begin
                    if (beat) begin
                        hdr_buf[0]   <= s_axis_tdata;
                        meta         <= s_axis_tuser;
                        vlan_id      <= vlan_in;
                        act_ram_addr <= vlan_in[7:4];
                        hdr_last     <= s_axis_tlast;
                        count        <= BEAT_CNT_W'(1);
                    end
                end
                HDR: begin
                    if (beat) begin
                        hdr_buf[count] <= s_axis_tdata;
                        hdr_last       <= s_axis_tlast;
                        if (!(s_axis_tlast || (count == BEAT_CNT_W'(HDR_BEATS - 1)))) begin
                            count <= count + BEAT_CNT_W'(1);
                        end
                    end
                end
                EXTRACT: phv_out <= phv_next;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < int'(NUM_ACTIONS); i++) begin : g_fx
        field_extract u_fx (
            .hdr    (hdr_flat),
            .action (act_ram_dout[act_base(i) +: ACT_W]),
            .value  (fx_value[i]),
            .kind   (fx_kind[i]),
            .idx    (fx_idx[i]),
            .valid  (fx_valid[i])
        );
    end

    // Later actions overwrite earlier ones targeting the same container
    always_comb begin
        phv_next = '0;
        base     = '0;
        phv_next[PHV_META_POS +: AXIS_USER_W] = meta;
        phv_next[PHV_VLAN_POS +: VLAN_W]      = vlan_id;
        for (int i = 0; i < int'(NUM_ACTIONS); i++) begin
            base = container_base(fx_kind[i], fx_idx[i]);
            if (fx_valid[i]) begin
                case (fx_kind[i])
                    TYPE_2B: phv_next[base +: 16] = fx_value[i][15:0];
                    TYPE_4B: phv_next[base +: 32] = fx_value[i][31:0];
                    TYPE_6B: phv_next[base +: 48] = fx_value[i];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_header_parser.sv
// Randomized scoreboard bench for header_parser with a byte-level PHV reference model.
module tb_header_parser;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [255:0]   s_axis_tdata;
    logic [31:0]    s_axis_tkeep;
    logic [127:0]   s_axis_tuser;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic [255:0]   m_pkt_tdata;
    logic [31:0]    m_pkt_tkeep;
    logic [127:0]   m_pkt_tuser;
    logic           m_pkt_tlast;
    logic           m_pkt_tvalid;
    logic           m_pkt_tready;
    logic [1123:0]  phv_out;
    logic           phv_valid;
    logic           phv_ready;
    logic [3:0]     act_ram_addr;
    logic [259:0]   act_ram_dout;

    logic [259:0]   ram [16];
    logic [255:0]   pkt_data [8];
    logic [127:0]   pkt_user [8];
    beat_t          exp_pkt_q [$];
    logic [1123:0]  exp_phv_q [$];

    int  n_checks = 0;
    int  n_pass   = 0;
    int  phv_stall = 0;
    bit  rand_ready = 0;
    bit  rand_phv   = 0;
    bit  gaps       = 0;

    always #5 clk = ~clk;

    header_parser dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_pkt_tdata   (m_pkt_tdata),
        .m_pkt_tkeep   (m_pkt_tkeep),
        .m_pkt_tuser   (m_pkt_tuser),
        .m_pkt_tlast   (m_pkt_tlast),
        .m_pkt_tvalid  (m_pkt_tvalid),
        .m_pkt_tready  (m_pkt_tready),
        .phv_out       (phv_out),
        .phv_valid     (phv_valid),
        .phv_ready     (phv_ready),
        .act_ram_addr  (act_ram_addr),
        .act_ram_dout  (act_ram_dout)
    );

    // Parse-action RAM with one cycle of read latency
    always @(posedge clk) act_ram_dout <= ram[act_ram_addr];

    task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic chk_phv(input logic [1123:0] got, input logic [1123:0] want, input string name);
        int d;
        d = 0;
        n_checks++;
        if (got === want) n_pass++;
        else begin
            for (int b = 1123; b >= 0; b--) if (got[b] !== want[b]) d = b;
            $display("FAIL %s: first differing bit %0d, got[%0d+:16]=%h want %h",
                     name, d, d, got[d +: 16], want[d +: 16]);
        end
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Reference: build the PHV from captured header bytes and the action list
    function automatic logic [1123:0] model_phv(input logic [7:0] hb [128], input logic [127:0] meta);
        logic [1123:0] p;
        logic [259:0]  ent;
        logic [15:0]   a;
        int k, t, off, pos;
        p   = '0;
        ent = ram[hb[15][7:4]];
        p[127:0]    = meta;
        p[129 +: 12] = {hb[14][3:0], hb[15]};
        for (int i = 0; i < 10; i++) begin
            a   = ent[244 - 16*i +: 16];
            k   = int'(a[3:1]);
            t   = int'(a[5:4]);
            off = int'(a[12:6]);
            if (a[0] && t != 0) begin
                pos = (t == 1) ? 356 + 16*k : (t == 2) ? 484 + 32*k : 740 + 48*k;
                for (int b = 0; b < 2*t; b++)
                    p[pos + 8*b +: 8] = (off + b < 128) ? hb[off + b] : 8'h00;
            end
        end
        return p;
    endfunction

    task automatic send_beat(input beat_t b);
        int waited;
        waited = 0;
        s_axis_tdata  = b.data;
        s_axis_tkeep  = b.keep;
        s_axis_tuser  = b.user;
        s_axis_tlast  = b.last;
        s_axis_tvalid = 1'b1;
        exp_pkt_q.push_back(b);
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            waited++;
            if (waited > 2000) begin
                chk(1'b0, "tready_timeout", 64'(waited), 64'd0);
                finish_run();
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n);
        logic [7:0] hb [128];
        beat_t b;
        for (int j = 0; j < 128; j++)
            hb[j] = (j / 32 < n) ? pkt_data[j / 32][8 * (j % 32) +: 8] : 8'h00;
        exp_phv_q.push_back(model_phv(hb, pkt_user[0]));
        for (int i = 0; i < n; i++) begin
            b.data = pkt_data[i];
            b.keep = $urandom;
            b.user = pkt_user[i];
            b.last = (i == n - 1);
            send_beat(b);
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic fill_pkt();
        for (int i = 0; i < 8; i++) begin
            for (int w = 0; w < 8; w++) pkt_data[i][32*w +: 32] = $urandom;
            pkt_user[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic wait_phv(input string name);
        int n;
        n = 0;
        while (!phv_valid && n < 50) begin @(negedge clk); n++; end
        if (!phv_valid) begin
            chk(1'b0, name, 64'd0, 64'd1);
            finish_run();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_pkt_q.size() != 0 || exp_phv_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 3000, "drain", 64'(exp_pkt_q.size()), 64'(exp_phv_q.size()));
        repeat (3) @(posedge clk);
        #1;
    endtask

    // m_pkt_tready driver
    initial begin
        m_pkt_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_pkt_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // PHV monitor: drives phv_ready, checks stalls and handshakes
    initial begin
        logic [1123:0] want;
        phv_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (phv_valid && phv_stall > 0) begin
                    phv_ready = 1'b0;
                    phv_stall--;
                    chk(!s_axis_tready, "stall_tready", 64'(s_axis_tready), 64'd0);
                    chk(!m_pkt_tvalid, "stall_m_tvalid", 64'(m_pkt_tvalid), 64'd0);
                    if (exp_phv_q.size() != 0) chk_phv(phv_out, exp_phv_q[0], "stall_phv_hold");
                end else begin
                    phv_ready = rand_phv ? ($urandom_range(0, 9) < 7) : 1'b1;
                end
                if (phv_valid && phv_ready) begin
                    if (exp_phv_q.size() == 0) chk(1'b0, "phv_unexpected", 64'd1, 64'd0);
                    else begin
                        want = exp_phv_q.pop_front();
                        chk_phv(phv_out, want, "phv");
                    end
                end
            end
        end
    end

    // Packet monitor
    initial begin
        beat_t got, want;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (s_axis_tvalid)
                    chk((s_axis_tvalid && s_axis_tready) == (m_pkt_tvalid && m_pkt_tready),
                        "xfer_align", 64'(s_axis_tready), 64'(m_pkt_tready));
                if (m_pkt_tvalid && m_pkt_tready) begin
                    got = '{m_pkt_tdata, m_pkt_tkeep, m_pkt_tuser, m_pkt_tlast};
                    if (exp_pkt_q.size() == 0) chk(1'b0, "pkt_unexpected", 64'd1, 64'd0);
                    else begin
                        want = exp_pkt_q.pop_front();
                        n_checks++;
                        if (got === want) n_pass++;
                        else $display("FAIL pkt_beat: got data=%h last=%b want data=%h last=%b",
                                      got.data, got.last, want.data, want.last);
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int e = 0; e < 16; e++)
            for (int w = 0; w < 9; w++) ram[e][32*w +: 32] = $urandom;
        // Directed entries: 3 -> 2B k=2 @12; 7 -> 6B k=7 @125; 9 -> 4B k=1 twice + invalid k=3
        ram[3] = '0;
        ram[3][244 +: 16] = {3'b0, 7'd12, 2'b01, 3'd2, 1'b1};
        ram[7] = '0;
        ram[7][244 - 48 +: 16] = {3'b0, 7'd125, 2'b11, 3'd7, 1'b1};
        ram[9] = '0;
        ram[9][244 - 32 +: 16] = {3'b0, 7'd20, 2'b10, 3'd1, 1'b1};
        ram[9][244 - 80 +: 16] = {3'b0, 7'd40, 2'b10, 3'd1, 1'b1};
        ram[9][244 - 96 +: 16] = {3'b0, 7'd50, 2'b10, 3'd3, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!s_axis_tready, "rst_tready", 64'(s_axis_tready), 64'd0);
        chk(!m_pkt_tvalid, "rst_m_tvalid", 64'(m_pkt_tvalid), 64'd0);
        chk(!phv_valid, "rst_phv_valid", 64'(phv_valid), 64'd0);
        chk(phv_out == '0, "rst_phv_out", 64'(phv_out[63:0]), 64'd0);
        chk(act_ram_addr == 4'd0, "rst_ram_addr", 64'(act_ram_addr), 64'd0);
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1-beat packet, VLAN 0x035, EtherType field extraction and latency
        fill_pkt();
        pkt_data[0][8*12 +: 8] = 8'h81;
        pkt_data[0][8*13 +: 8] = 8'h00;
        pkt_data[0][8*14 +: 8] = 8'h00;
        pkt_data[0][8*15 +: 8] = 8'h35;
        send_pkt(1);
        chk(act_ram_addr == 4'd3, "t1_ram_addr", 64'(act_ram_addr), 64'd3);
        @(negedge clk);
        chk(!phv_valid, "t1_lat_c1", 64'(phv_valid), 64'd0);
        @(negedge clk);
        chk(!phv_valid, "t1_lat_c2", 64'(phv_valid), 64'd0);
        @(negedge clk);
        chk(phv_valid, "t1_lat_c3", 64'(phv_valid), 64'd1);
        chk(phv_out[388 +: 16] == 16'h0081, "t1_etype", 64'(phv_out[388 +: 16]), 64'h0081);
        chk(phv_out[129 +: 12] == 12'h035, "t1_vlan", 64'(phv_out[129 +: 12]), 64'h035);
        wait_idle();

        // 4-beat header + 2 body beats, PHV held off 5 cycles
        fill_pkt();
        phv_stall = 5;
        send_pkt(6);
        wait_idle();
        chk(phv_stall == 0, "t2_stall_used", 64'(phv_stall), 64'd0);

        // 6B container 7 reading bytes 125..127 then past the header
        fill_pkt();
        pkt_data[0][8*15 +: 8] = 8'h7c;
        send_pkt(4);
        wait_phv("t3_phv_timeout");
        chk(phv_out[1076 +: 48] == {24'd0, pkt_data[3][255:232]}, "t3_6b_edge",
            64'(phv_out[1076 +: 48]), 64'({24'd0, pkt_data[3][255:232]}));
        wait_idle();

        // Two actions hit 4B container 1; invalid action leaves container 3 empty
        fill_pkt();
        pkt_data[0][8*15 +: 8] = 8'h9a;
        send_pkt(2);
        wait_phv("t4_phv_timeout");
        chk(phv_out[516 +: 32] == pkt_data[1][64 +: 32], "t4_last_wins",
            64'(phv_out[516 +: 32]), 64'(pkt_data[1][64 +: 32]));
        chk(phv_out[580 +: 32] == 32'd0, "t4_invalid_empty", 64'(phv_out[580 +: 32]), 64'd0);
        wait_idle();

        // m_pkt_tready toggling while the header is captured
        fill_pkt();
        rand_ready = 1'b1;
        send_pkt(5);
        wait_idle();
        rand_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Reset after two header beats, then a clean 1-beat packet
        begin
            beat_t b;
            fill_pkt();
            pkt_data[0][8*15 +: 8] = 8'h91;
            for (int i = 0; i < 2; i++) begin
                b = '{pkt_data[i], 32'hffff_ffff, pkt_user[i], 1'b0};
                send_beat(b);
            end
            rst = 1'b1;
            s_axis_tvalid = 1'b1;
            @(negedge clk);
            chk(!s_axis_tready, "t6_rst_tready", 64'(s_axis_tready), 64'd0);
            chk(!m_pkt_tvalid, "t6_rst_m_tvalid", 64'(m_pkt_tvalid), 64'd0);
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk(!phv_valid, "t6_phv_valid", 64'(phv_valid), 64'd0);
            chk(s_axis_tready, "t6_idle_ready", 64'(s_axis_tready), 64'd1);
            @(posedge clk);
            #1;
            fill_pkt();
            pkt_data[0][8*15 +: 8] = 8'h9f;
            send_pkt(1);
            wait_phv("t6_phv_timeout");
            chk(phv_out[516 +: 32] == 32'd0, "t6_zeroed_buf", 64'(phv_out[516 +: 32]), 64'd0);
            wait_idle();
        end

        // Random traffic with backpressure on both outputs and idle gaps
        rand_ready = 1'b1;
        rand_phv   = 1'b1;
        gaps       = 1'b1;
        for (int p = 0; p < 40; p++) begin
            fill_pkt();
            send_pkt($urandom_range(1, 7));
        end
        wait_idle();

        chk(exp_pkt_q.size() == 0, "end_pkt_q", 64'(exp_pkt_q.size()), 64'd0);
        chk(exp_phv_q.size() == 0, "end_phv_q", 64'(exp_phv_q.size()), 64'd0);
        finish_run();
    end

endmodule

// File: doc/header_parser.md
Name: header_parser

Overview:
- Ingress-side counterpart of the deparser. Accepts an AXI-Stream packet and captures its first up to 4 beats (128 B) as the header.
- Looks up the per-VLAN parse-action entry in the parse-action RAM, extracts up to 10 fields into a PHV, emits the PHV, and forwards the packet unchanged.
- PHV and packet leave in the same order, so the deparser can pair the PHV FIFO with the packet FIFO one-to-one.

Parameters:
- C_AXIS_DATA_WIDTH, 256, stream data width; fixed at 256.
- C_AXIS_TUSER_WIDTH, 128, stream user width.
- C_PKT_VEC_WIDTH, 1124, PHV width = (6+4+2)*8*8 + 20*5 + 256.
- C_NUM_ACTIONS, 10, parse actions per RAM entry.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_axis_tdata  in  256  input packet data; byte n is at bits [8n+:8].
- s_axis_tkeep  in  32  input byte enables.
- s_axis_tuser  in  128  input metadata.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  input last beat.
- s_axis_tready  out  1  input backpressure.
- m_pkt_tdata / tkeep / tuser / tlast  out  256/32/128/1  packet output to the packet FIFO.
- m_pkt_tvalid  out  1  packet output valid.
- m_pkt_tready  in  1  packet FIFO not full.
- phv_out  out  1124  PHV to the PHV FIFO.
- phv_valid  out  1  PHV valid.
- phv_ready  in  1  PHV FIFO not full.
- act_ram_addr  out  4  parse-action RAM read address.
- act_ram_dout  in  260  parse-action RAM read data; read latency is 1 cycle.

Behaviour:
- Reset: state=IDLE, s_axis_tready=0 for the reset cycle, m_pkt_tvalid=0, phv_valid=0, phv_out=0, act_ram_addr=0, beat count=0, header buffer zeroed.
- Beat acceptance: in IDLE, HDR and BODY, s_axis_tready = m_pkt_tready. A beat transfers when s_axis_tvalid && s_axis_tready.
  - Transferred beats pass through combinationally to m_pkt_*, with m_pkt_tvalid = s_axis_tvalid.
  - In LOOKUP, EXTRACT and EMIT, s_axis_tready=0 and m_pkt_tvalid=0.
- IDLE:
  - On a beat: store it in buffer slot 0 and latch s_axis_tuser into meta.
  - vlan_id = {tdata[115:112], tdata[127:120]}; register act_ram_addr <= vlan_id[7:4].
  - If tlast, go to LOOKUP; otherwise go to HDR with count=1.
  - At entry to IDLE, the buffer bytes are cleared.
- HDR:
  - Each beat is stored in slot count.
  - If tlast or count==3, go to LOOKUP; otherwise increment count.
- LOOKUP: one cycle, waiting for act_ram_dout. act_ram_addr is held stable.
- EXTRACT: one cycle. Decode action i from act_ram_dout[244-16*i +:16]:
  - bit 0 = valid.
  - [3:1] = container index k.
  - [5:4] = type: 01 = 2B, 10 = 4B, 11 = 6B, 00 = ignored.
  - [12:6] = byte offset.
  - Value = buf[offset*8 +: width]. Bytes at or beyond offset 128, and never-captured bytes, read 0.
  - Write to container k: 2B at 356+16k, 4B at 484+32k, 6B at 740+48k.
  - If several actions target the same container, the higher action index wins.
  - Unwritten containers are 0.
  - phv[0+:128] = meta, phv[128] = 0, phv[129+:12] = vlan_id, phv[141+:215] = 0.
  - Register phv_out, then go to EMIT.
- EMIT:
  - phv_valid=1, holding phv_out stable until phv_ready.
  - On the handshake, if the last captured beat was tlast go to IDLE, otherwise go to BODY.
- BODY: pass through beats until the tlast transfer, then go to IDLE.
- Latency: PHV is valid 2 cycles after the last header beat transfers. The body stalls until the PHV handshake completes.
- tkeep is forwarded unchanged; extraction does not inspect it.
- Packets longer than 4 beats: only beats 0-3 are parsed.
- Reset mid-packet returns the block to IDLE. The partial packet already forwarded stays truncated, and no PHV is emitted for it.

Decomposition:
- Package rmt_pkg holds:
  - PHV_2B/4B/6B_START_POS (356/484/740);
  - action field slices and the ACT_BASE(i)=244-16*i formula;
  - type encodings, the VLAN bit positions, and the state enum.
- One sub-module, field_extract: takes a 1024 b buffer and one 16 b action, and outputs a 48 b value, 2 b type, 3 b index and a valid. It is instantiated 10 times.

Test Plan:
- 1-beat packet, VLAN 0x035 → act_ram_addr=3; action0 = valid, type 01, k=2, offset 12 → phv[388+:16] = bytes 12-13 (EtherType 0x0081 lane order); phv_valid 2 cycles after the tlast beat; packet forwarded byte-exact.
- 4-beat header + 2 body beats with phv_ready held low 5 cycles → s_axis_tready=0 throughout; PHV stable; body forwarded after the handshake; beat order intact.
- Action type 11, k=7, offset 125 → phv[1076+:48] = bytes 125-127 in the low 24 b, upper 24 b zero.
- Actions 2 and 5 both target 4B container 1 → container holds action 5's value; an action with valid=0 leaves its container 0.
- m_pkt_tready toggled in HDR → a beat transfers only with tready high; no duplicate or lost beats.
- rst asserted in HDR after 2 beats → next cycle state IDLE, phv_valid=0; the next packet parses correctly with a zeroed buffer.
